// File: rtl/intr_rx_pkg.sv
// Shared types and helpers for the interrupt receive controller.
// Gateway state encoding doubles as the {ip, is} bit pair.
package intr_rx_pkg;

    localparam int MaxSrc = 31;
    localparam int MaxIdW = 5;
    localparam int IdNone = 0;

    typedef enum logic [1:0] {
        GwIdle      = 2'b00,
        GwPending   = 2'b10,
        GwInService = 2'b01
    } gw_state_e;

    // Lowest index wins; returns 1-based ID or IdNone.
    function automatic logic [MaxIdW-1:0] best_id(
        input logic [MaxSrc-1:0] elig
    );
        logic [MaxIdW-1:0] id;
        id = MaxIdW'(IdNone);
        for (int i = MaxSrc - 1; i >= 0; i--) begin
            if (elig[i]) begin
                id = MaxIdW'(i + 1);
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/intr_rx_gateway.sv
// Per-source gateway: trigger detection plus IDLE/PENDING/IN_SERVICE.
// Triggers arriving while not idle are dropped.
module intr_rx_gateway
    import intr_rx_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic src_i,
    input  logic le_i,
    input  logic claim_i,
    input  logic complete_i,
    output logic ip_o,
    output logic is_o
);

    gw_state_e state_q, state_d;
    logic      src_q;
    logic      trig;

    assign trig = src_i & (~le_i | ~src_q);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            GwIdle: begin
                if (trig) begin
                    state_d = GwPending;
                end
            end
            GwPending: begin
                if (claim_i) begin
                    state_d = GwInService;
                end
            end
            GwInService: begin
                if (complete_i) begin
                    state_d = GwIdle;
                end
            end
            default: state_d = GwIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= GwIdle;
            src_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_i;
        end
    end

    assign ip_o = state_q[1];
    assign is_o = state_q[0];

endmodule

// File: rtl/intr_rx_ctrl.sv
// Interrupt receive controller: gateways, fixed-priority select,
// claim/complete handshake and registered core-facing outputs.
module intr_rx_ctrl
    import intr_rx_pkg::*;
#(
    parameter int NumSrc = 8,
    localparam int IdW = $clog2(NumSrc + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumSrc-1:0] intr_src_i,
    input  logic [NumSrc-1:0] le_i,
    input  logic [NumSrc-1:0] ie_i,
    input  logic              claim_req_i,
    output logic              claim_valid_o,
    output logic [IdW-1:0]    claim_id_o,
    input  logic              complete_we_i,
    input  logic [IdW-1:0]    complete_id_i,
    output logic [NumSrc-1:0] ip_o,
    output logic              irq_o,
    output logic [IdW-1:0]    irq_id_o
);

    logic [NumSrc-1:0] ip;
    logic [NumSrc-1:0] is;
    logic [NumSrc-1:0] elig;
    logic [NumSrc-1:0] claim_vec;
    logic [NumSrc-1:0] cmpl_vec;
    logic [MaxSrc-1:0] elig_ext;
    logic [IdW-1:0]    best;

    logic           claim_valid_q;
    logic [IdW-1:0] claim_id_q, claim_id_d;
    logic           irq_q;
    logic [IdW-1:0] irq_id_q;

    assign elig     = ip & ie_i & ~is;
    assign elig_ext = MaxSrc'(elig);
    assign best     = IdW'(best_id(elig_ext));

    for (genvar g = 0; g < NumSrc; g++) begin : g_gw
        assign claim_vec[g] = claim_req_i
                            & (best == IdW'(g + 1));
        assign cmpl_vec[g]  = complete_we_i
                            & (complete_id_i == IdW'(g + 1));

        intr_rx_gateway u_gw (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .src_i      (intr_src_i[g]),
            .le_i       (le_i[g]),
            .claim_i    (claim_vec[g]),
            .complete_i (cmpl_vec[g]),
            .ip_o       (ip[g]),
            .is_o       (is[g])
        );
    end

    always_comb begin
        claim_id_d = claim_id_q;
        if (claim_req_i) begin
            claim_id_d = best;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            claim_valid_q <= 1'b0;
            claim_id_q    <= '0;
            irq_q         <= 1'b0;
            irq_id_q      <= '0;
        end else begin
            claim_valid_q <= claim_req_i;
            claim_id_q    <= claim_id_d;
            irq_q         <= |elig;
            irq_id_q      <= best;
        end
    end

    assign ip_o          = ip;
    assign claim_valid_o = claim_valid_q;
    assign claim_id_o    = claim_id_q;
    assign irq_o         = irq_q;
    assign irq_id_o      = irq_id_q;

endmodule

// File: tb/tb_intr_rx_ctrl.sv
// Self-checking bench for intr_rx_ctrl.
// Directed scenarios followed by a randomized run against a reference model.
module tb_intr_rx_ctrl;

    localparam int N = 8;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] src, le, ie;
    logic         claim, cwe;
    logic [W-1:0] cid;
    logic         claim_valid;
    logic [W-1:0] claim_id;
    logic [N-1:0] ip;
    logic         irq;
    logic [W-1:0] irq_id;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    bit [N-1:0] m_pend, m_svc, m_prev;
    int         m_irq_id, m_cid;
    bit         m_irq, m_cv;

    always #5 clk = ~clk;

    intr_rx_ctrl #(.NumSrc(N)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .intr_src_i    (src),
        .le_i          (le),
        .ie_i          (ie),
        .claim_req_i   (claim),
        .claim_valid_o (claim_valid),
        .claim_id_o    (claim_id),
        .complete_we_i (cwe),
        .complete_id_i (cid),
        .ip_o          (ip),
        .irq_o         (irq),
        .irq_id_o      (irq_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".ip"}, 32'(ip), 32'(m_pend));
        chk({tag, ".irq"}, 32'(irq), 32'(m_irq));
        chk({tag, ".irq_id"}, 32'(irq_id), 32'(m_irq_id));
        chk({tag, ".cvalid"}, 32'(claim_valid), 32'(m_cv));
        chk({tag, ".cid"}, 32'(claim_id), 32'(m_cid));
    endtask

    // one clock: model computes next state from pre-edge state and inputs
    task automatic step(input string tag);
        bit [N-1:0] elig, np, ns;
        int best;
        elig = m_pend & ie & ~m_svc;
        best = 0;
        for (int i = N - 1; i >= 0; i--)
            if (elig[i]) best = i + 1;
        np = m_pend;
        ns = m_svc;
        for (int i = 0; i < N; i++) begin
            bit fire;
            fire = src[i] && (!le[i] || !m_prev[i]);
            if (!m_pend[i] && !m_svc[i] && fire) np[i] = 1'b1;
        end
        if (claim && best != 0) begin
            np[best-1] = 1'b0;
            ns[best-1] = 1'b1;
        end
        if (cwe && cid >= 1 && cid <= N && m_svc[cid-1])
            ns[cid-1] = 1'b0;
        m_irq    = (elig != 0);
        m_irq_id = best;
        m_cv     = claim;
        if (claim) m_cid = best;
        @(posedge clk);
        #1;
        m_pend = np;
        m_svc  = ns;
        m_prev = src;
        chk_all(tag);
    endtask

    task automatic idle_in();
        claim = 1'b0;
        cwe   = 1'b0;
        cid   = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        src = '0;
        le  = '0;
        ie  = '0;
        idle_in();
        m_pend = '0; m_svc = '0; m_prev = '0;
        m_irq = 0; m_irq_id = 0; m_cv = 0; m_cid = 0;
        @(posedge clk);
        #1;
        chk_all("reset");
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // level basic
        ie = 8'hFF; src = 8'h04;
        step("lvl0");
        chk("lvl_ip_set", 32'(ip), 32'h04);
        step("lvl1");
        chk("lvl_irq", 32'(irq), 32'd1);
        chk("lvl_irq_id", 32'(irq_id), 32'd3);
        claim = 1; step("lvl_claim");
        chk("lvl_claim_id", 32'(claim_id), 32'd3);
        chk("lvl_ip_clr", 32'(ip), 32'h00);
        claim = 0; step("lvl2");
        chk("lvl_irq_off", 32'(irq), 32'd0);
        cwe = 1; cid = 3; step("lvl_cmpl");
        idle_in(); step("lvl3");
        chk("lvl_repend", 32'(ip), 32'h04);

        // priority
        do_reset();
        ie = 8'hFF; src = 8'h24;
        step("pri0"); step("pri1");
        chk("pri_irq_id", 32'(irq_id), 32'd3);
        claim = 1; step("pri_c1");
        chk("pri_cid1", 32'(claim_id), 32'd3);
        step("pri_c2");
        chk("pri_cid2", 32'(claim_id), 32'd6);
        chk("pri_irq_id6", 32'(irq_id), 32'd6);
        claim = 0; step("pri2");

        // edge drop
        do_reset();
        ie = 8'hFF; le = 8'h01;
        src = 8'h01; step("e0");
        src = 8'h00; step("e1");
        claim = 1; step("e2");
        claim = 0; step("e3");
        src = 8'h01; step("e4");
        src = 8'h00; step("e5");
        chk("edge_drop", 32'(ip[0]), 32'd0);
        cwe = 1; cid = 1; step("e6");
        idle_in();
        for (int i = 0; i < 3; i++) step("e7");
        src = 8'h01; step("e10");
        chk("edge_repend", 32'(ip[0]), 32'd1);
        src = 8'h00; step("e11");

        // disabled and empty
        do_reset();
        ie = 8'h00; src = 8'h02;
        step("d0"); step("d1");
        chk("dis_ip", 32'(ip), 32'h02);
        chk("dis_irq", 32'(irq), 32'd0);
        claim = 1; step("d_claim");
        chk("dis_cvalid", 32'(claim_valid), 32'd1);
        chk("dis_cid", 32'(claim_id), 32'd0);
        chk("dis_ip_keep", 32'(ip), 32'h02);
        claim = 0;

        // bad complete, then same-cycle claim/complete
        ie = 8'hFF;
        cwe = 1; cid = 0; step("bad0");
        cid = 9; step("bad9");
        idle_in();
        do_reset();
        ie = 8'hFF; src = 8'h01;
        step("sc0");
        claim = 1; step("sc_claim1");
        claim = 0; src = 8'h02; step("sc1");
        claim = 1; cwe = 1; cid = 1; step("sc_both");
        chk("sc_cid", 32'(claim_id), 32'd2);
        idle_in(); src = 8'h00; step("sc2");
        cwe = 1; cid = 1; step("sc_recmpl");
        idle_in(); step("sc3");

        // randomized run
        do_reset();
        for (int k = 0; k < 400; k++) begin
            src   = N'($urandom);
            if (k % 50 == 0) le = N'($urandom);
            if (k % 17 == 0) ie = N'($urandom) | 8'h0F;
            claim = ($urandom_range(0, 99) < 30);
            cwe   = ($urandom_range(0, 99) < 35);
            cid   = W'($urandom_range(0, 10));
            step("rnd");
        end
        idle_in();

        // async reset mid-service
        do_reset();
        ie = 8'hFF; src = 8'h03;
        step("ar0");
        claim = 1; step("ar1"); step("ar2");
        claim = 0; src = 8'h04; step("ar3"); step("ar4");
        chk("ar_irq_pre", 32'(irq), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_ip", 32'(ip), 32'd0);
        chk("ar_irq", 32'(irq), 32'd0);
        chk("ar_irq_id", 32'(irq_id), 32'd0);
        chk("ar_cvalid", 32'(claim_valid), 32'd0);
        chk("ar_cid", 32'(claim_id), 32'd0);
        do_reset();
        step("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
